mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped timer/compare peripheral on the MIPS data-memory bus.
//  It is the responder to CPU sw/lw: it decodes the address, accepts stores and returns load data.
//  It counts prescaled clock ticks and sets a sticky match flag when COUNT equals COMPARE.
//  The flag drives an interrupt line to the system.
// PARAMETERS
//  WIDTH    32  width of COUNT, COMPARE and the data bus
//  PRE_W    8   width of the prescaler field and of the prescaler counter
// PORTS
//  clk      in   1      system clock; all state updates on posedge
//  reset    in   1      synchronous, active-high reset
//  cs       in   1      chip select from the address decoder (one access per cycle)
//  we       in   1      store strobe; qualified by cs
//  addr     in   4      byte address; addr[3:2] selects the register, addr[1:0] ignored
//  wdata    in   WIDTH  store data
//  rdata    out  WIDTH  load data; combinational
//  irq      out  1      interrupt request, level, = MATCH & IRQEN
// BEHAVIOUR
//  Register map (addr[3:2]):
//   0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN, [8+:PRE_W] PRESCALE; other bits read 0.
//   1 COUNT: R/W; a write loads COUNT and clears the prescaler counter.
//   2 COMPARE: R/W.
//   3 STATUS: bit0 MATCH, sticky; writing 1 to bit0 clears it (W1C); writing 0 has no effect.
//  Reset (reset=1 at posedge):
//   - CTRL, COUNT, COMPARE, MATCH and pcnt all go to 0.
//   - irq=0. Reset overrides any bus write or tick in the same cycle.
//  Reads:
//   - rdata = selected register while cs=1 && we=0; otherwise rdata = 0.
//   - Zero latency, same as regfile read ports.
//  Writes: take effect at the posedge where cs=1 && we=1; visible to a read the next cycle.
//  Prescaler:
//   - While EN=0, pcnt is held at 0 and there are no ticks.
//   - While EN=1, tick = (pcnt == PRESCALE). On tick pcnt <= 0, else pcnt <= pcnt+1.
//   - PRESCALE=0 gives a tick every cycle. PRESCALE=N gives a tick every N+1 cycles.
//   - Writing CTRL with a new PRESCALE does not clear pcnt.
//     If pcnt > the new PRESCALE, pcnt counts up, wraps modulo 2^PRE_W, then reaches PRESCALE.
//  Count, evaluated on tick:
//   - If COUNT == COMPARE: set MATCH. COUNT <= AUTORELOAD ? 0 : COUNT+1.
//   - Otherwise COUNT <= COUNT+1, mod 2^WIDTH (0xFFFFFFFF -> 0, no flag).
//   - COUNT == COMPARE is compared against the pre-update COUNT.
//  Simultaneous events (same posedge):
//   - Bus write to COUNT plus a tick: the written value wins, pcnt <= 0, no match evaluation.
//   - Bus write to COMPARE plus a tick: the match compares against the old COMPARE.
//   - W1C of MATCH plus MATCH being set: set wins, MATCH stays 1.
//   - Write to CTRL clearing EN plus a tick: the tick still applies; pcnt is 0 from the next cycle.
//  irq is combinational from registered MATCH/IRQEN, so it is glitch-free.
//   - It rises the cycle after MATCH is set (or IRQEN is written 1).
//   - It falls the cycle after the W1C (or IRQEN is written 0).
// TESTING
//  1 Reset mid-count:
//    - Setup: EN=1, COUNT=7; assert reset for 1 cycle.
//    - Result: all four registers read 0, irq=0; COUNT stays 0 (EN=0).
//  2 PRESCALE=0, COMPARE=5, EN=1, IRQEN=1, no autoreload:
//    - COUNT reads 1,2,..., one step per cycle.
//    - On the tick where COUNT was 5: COUNT becomes 6 and MATCH=1; irq=1 that next cycle.
//  3 PRESCALE=3, AUTORELOAD=1, COMPARE=2:
//    - COUNT steps every 4 cycles in the sequence 0,1,2,0,1,...
//    - MATCH sets on the 3rd tick, 12 cycles after enable.
//  4 Wrap-around:
//    - Setup: write COUNT=0xFFFFFFFF, COMPARE=0, PRESCALE=0, EN=1.
//    - Next cycle COUNT=0 and MATCH=0; the following cycle COUNT=1 and MATCH=1.
//  5 Collisions:
//    - A COUNT=0x100 write on a tick cycle reads back 0x100.
//    - A W1C of STATUS on the cycle MATCH sets leaves STATUS=1; a later W1C clears it.
//    - irq drops the next cycle.
//  6 Bus decode:
//    - cs=0 with addr=0xC gives rdata=0.
//    - A we=1 write with cs=0 leaves registers unchanged.
//    - addr=0x9 reads COMPARE.
//    - CTRL write 0xFFFFFFFF reads back 0x0000FF07 (PRE_W=8).

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the data-memory bus: prescaled counter,
// compare register and a sticky match flag that drives a level interrupt.
module mmio_timer #(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [PRE_W-1:0] PCNT_ONE  = PRE_W'(1);
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    logic             en_q, en_d;
    logic             autoreload_q, autoreload_d;
    logic             irqen_q, irqen_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic             match_q, match_d;

    logic [1:0]       sel;
    logic             wr;
    logic             tick;
    logic [WIDTH-1:0] ctrl_view;
    logic             unused_addr_lo;

    // Bus: one access per cycle while cs=1; we=1 is a store committed at the next
    // posedge, we=0 is a load answered combinationally in the same cycle.
    assign sel            = addr[3:2];
    assign wr             = cs & we;
    assign tick           = en_q && (pcnt_q == prescale_q);
    assign unused_addr_lo = &{1'b0, addr[1:0]};

    always_comb begin
        ctrl_view               = '0;
        ctrl_view[0]            = en_q;
        ctrl_view[1]            = autoreload_q;
        ctrl_view[2]            = irqen_q;
        ctrl_view[8 +: PRE_W]   = prescale_q;
    end

    always_comb begin
        rdata = '0;
        if (cs && !we) begin
            case (sel)
                REG_CTRL:    rdata = ctrl_view;
                REG_COUNT:   rdata = count_q;
                REG_COMPARE: rdata = compare_q;
                REG_STATUS:  rdata = {{(WIDTH-1){1'b0}}, match_q};
                default:     rdata = '0;
            endcase
        end
    end

    assign irq = match_q & irqen_q;

    always_comb begin
        en_d         = en_q;
        autoreload_d = autoreload_q;
        irqen_d      = irqen_q;
        prescale_d   = prescale_q;
        pcnt_d       = pcnt_q;
        count_d      = count_q;
        compare_d    = compare_q;
        match_d      = match_q;

        // Prescaler and count use the pre-write CTRL/COMPARE values of this cycle.
        if (!en_q) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end

        if (wr && (sel == REG_STATUS) && wdata[0]) begin
            match_d = 1'b0;
        end

        if (tick) begin
            if (count_q == compare_q) begin
                count_d = autoreload_q ? '0 : count_q + COUNT_ONE;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end

        if (wr) begin
            case (sel)
                REG_CTRL: begin
                    en_d         = wdata[0];
                    autoreload_d = wdata[1];
                    irqen_d      = wdata[2];
                    prescale_d   = wdata[8 +: PRE_W];
                end
                REG_COUNT: begin
                    count_d = wdata;
                    pcnt_d  = '0;
                end
                REG_COMPARE: compare_d = wdata;
                default: ;
            endcase
        end

        // A bus write to COUNT suppresses match evaluation; setting beats a W1C.
        if (tick && (count_q == compare_q) && !(wr && (sel == REG_COUNT))) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q         <= 1'b0;
            autoreload_q <= 1'b0;
            irqen_q      <= 1'b0;
            prescale_q   <= '0;
            pcnt_q       <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            match_q      <= 1'b0;
        end else begin
            en_q         <= en_d;
            autoreload_q <= autoreload_d;
            irqen_q      <= irqen_d;
            prescale_q   <= prescale_d;
            pcnt_q       <= pcnt_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            match_q      <= match_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: hand-computed register and irq values per cycle.
module tb_mmio_timer;

    localparam int W = 32;

    localparam logic [3:0] A_CTRL    = 4'h0;
    localparam logic [3:0] A_COUNT   = 4'h4;
    localparam logic [3:0] A_COMPARE = 4'h8;
    localparam logic [3:0] A_STATUS  = 4'hC;

    logic         clk;
    logic         reset;
    logic         cs;
    logic         we;
    logic [3:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         irq;

    int n_vec;
    int n_err;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rd_val;

    mmio_timer #(.WIDTH(32), .PRE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [W-1:0] d);
        cs    = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [W-1:0] d);
        cs   = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d    = rdata;
        cs   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [W-1:0] exp);
        logic [W-1:0] v;
        bus_rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        cycles(2);
        reset = 1'b0;

        // 1: reset mid-count
        bus_wr(A_COUNT, 32'd7);
        bus_wr(A_CTRL, 32'h1);
        cycles(2);
        check_reg("pre_reset_count", A_COUNT, 32'd9);
        do_reset();
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check_reg("rst_count", A_COUNT, 32'h0);
        check_reg("rst_compare", A_COMPARE, 32'h0);
        check_reg("rst_status", A_STATUS, 32'h0);
        check_irq("rst_irq", 1'b0);
        cycles(3);
        check_reg("rst_count_held", A_COUNT, 32'h0);

        // 2: prescale 0, compare 5, irq enabled
        bus_wr(A_COMPARE, 32'd5);
        bus_wr(A_CTRL, 32'h5);
        check_reg("en_count0", A_COUNT, 32'd0);
        for (int i = 1; i <= 6; i++) exp_q.push_back(W'(i));
        for (int i = 1; i <= 6; i++) begin
            cycles(1);
            bus_rd(A_COUNT, rd_val);
            check("step_count", rd_val, exp_q.pop_front());
            check_reg("step_status", A_STATUS, (i == 6) ? 32'd1 : 32'd0);
            check_irq("step_irq", i == 6);
        end
        bus_wr(A_CTRL, 32'h0);
        check_reg("disable_tick_count", A_COUNT, 32'd7);
        check_reg("sticky_status", A_STATUS, 32'd1);
        cycles(2);
        check_reg("disabled_count", A_COUNT, 32'd7);
        bus_wr(A_STATUS, 32'h1);
        check_reg("w1c_status", A_STATUS, 32'd0);

        // 3: prescale 3, autoreload, compare 2
        do_reset();
        bus_wr(A_COMPARE, 32'd2);
        bus_wr(A_CTRL, 32'h303);
        cycles(3);
        check_reg("pre_c3", A_COUNT, 32'd0);
        cycles(1);
        check_reg("pre_c4", A_COUNT, 32'd1);
        cycles(3);
        check_reg("pre_c7", A_COUNT, 32'd1);
        cycles(1);
        check_reg("pre_c8", A_COUNT, 32'd2);
        cycles(3);
        check_reg("pre_c11_status", A_STATUS, 32'd0);
        cycles(1);
        check_reg("pre_c12_count", A_COUNT, 32'd0);
        check_reg("pre_c12_status", A_STATUS, 32'd1);
        check_irq("irqen_off", 1'b0);
        cycles(4);
        check_reg("pre_c16", A_COUNT, 32'd1);
        bus_wr(A_CTRL, 32'h307);
        check_irq("irqen_on", 1'b1);
        check_reg("ctrl_rb", A_CTRL, 32'h307);

        // 4: wrap-around
        do_reset();
        bus_wr(A_COUNT, 32'hFFFF_FFFF);
        bus_wr(A_COMPARE, 32'h0);
        bus_wr(A_CTRL, 32'h1);
        check_reg("wrap_start", A_COUNT, 32'hFFFF_FFFF);
        cycles(1);
        check_reg("wrap_count0", A_COUNT, 32'h0);
        check_reg("wrap_status0", A_STATUS, 32'h0);
        cycles(1);
        check_reg("wrap_count1", A_COUNT, 32'h1);
        check_reg("wrap_status1", A_STATUS, 32'h1);

        // 5: collisions
        bus_wr(A_COUNT, 32'h100);
        check_reg("count_wr_on_tick", A_COUNT, 32'h100);
        do_reset();
        bus_wr(A_COMPARE, 32'd3);
        bus_wr(A_CTRL, 32'h5);
        cycles(3);
        check_reg("col_pre", A_COUNT, 32'd3);
        bus_wr(A_STATUS, 32'h1);
        check_reg("set_beats_w1c", A_STATUS, 32'd1);
        check_reg("set_count", A_COUNT, 32'd4);
        check_irq("set_irq", 1'b1);
        bus_wr(A_STATUS, 32'h0);
        check_reg("w0_no_effect", A_STATUS, 32'd1);
        bus_wr(A_STATUS, 32'h1);
        check_reg("later_w1c", A_STATUS, 32'd0);
        check_irq("irq_drop", 1'b0);

        do_reset();
        bus_wr(A_COMPARE, 32'd2);
        bus_wr(A_CTRL, 32'h1);
        cycles(2);
        check_reg("cmp_col_pre", A_COUNT, 32'd2);
        bus_wr(A_COMPARE, 32'd9);
        check_reg("old_compare_match", A_STATUS, 32'd1);
        check_reg("new_compare", A_COMPARE, 32'd9);
        bus_wr(A_CTRL, 32'h0);
        check_reg("dis_tick_applies", A_COUNT, 32'd4);
        cycles(2);
        check_reg("dis_held", A_COUNT, 32'd4);

        // 6: bus decode
        cs = 1'b0; we = 1'b0; addr = 4'hC;
        #1;
        check("cs0_rdata", rdata, 32'h0);
        cs = 1'b1; we = 1'b1;
        #1;
        check("store_rdata", rdata, 32'h0);
        cs = 1'b0;
        we = 1'b1; addr = A_COUNT; wdata = 32'hDEAD;
        cycles(1);
        we = 1'b0; wdata = '0;
        check_reg("cs0_write_ignored", A_COUNT, 32'd4);
        check_reg("addr9_compare", 4'h9, 32'd9);
        bus_wr(A_CTRL, 32'hFFFF_FFFF);
        check_reg("ctrl_mask", A_CTRL, 32'h0000_FF07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
